// File: rtl/jamma_joy_scanner_pkg.sv
// Shared definitions for the JAMMA joystick scanner.
// Contents: scan FSM state encoding and idle (nothing-pressed) levels of the
// active-low player and coin buses.
package jamma_joy_scanner_pkg;

    typedef enum logic [1:0] {
        SETTLE1 = 2'd0,
        SAMPLE1 = 2'd1,
        SETTLE2 = 2'd2,
        SAMPLE2 = 2'd3
    } scan_state_e;

    localparam logic [7:0] JOY_IDLE  = 8'hFF;
    localparam logic [1:0] COIN_IDLE = 2'b11;

endpackage

// File: rtl/jamma_joy_scanner_debounce.sv
// Sample-count debouncer for one active-low input group.
// Ports:
//   pclk      - clock, rising edge
//   reset     - synchronous, active-high
//   sample_en - one-cycle strobe marking a valid sample of din
//   din       - raw sampled inputs (WIDTH bits)
//   dout      - debounced inputs; changes only after SAMPLES identical samples
// The whole group shares one candidate/counter, so any bit change restarts it.
module joy_debounce #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SAMPLES = 3
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic [3:0] CntTarget = 4'(SAMPLES);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [3:0]       cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (sample_en) begin
            if (din != cand_q) begin
                cand_d = din;
                cnt_d  = 4'd1;
            end else if (cnt_q < CntTarget) begin
                cnt_d = cnt_q + 4'd1;
            end
            // Accept on the same edge as the final matching sample.
            if (cnt_d == CntTarget) begin
                dout_d = cand_d;
            end
        end
    end

    // Reset state treats the idle level as already accepted.
    always_ff @(posedge pclk) begin
        if (reset) begin
            cand_q <= '1;
            cnt_q  <= CntTarget;
            dout_q <= '1;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/jamma_joy_scanner.sv
// Two-player JAMMA joystick splitter sequencer with debounced outputs.
// Ports:
//   pclk       - pixel clock, rising edge
//   reset      - synchronous, active-high
//   jjoy       - shared active-low joystick bus, valid for the selected player
//   local_joy  - on-board active-low joystick, merged into player 1
//   jcoin      - active-low coin switches (not multiplexed)
//   joy_select - splitter select, 0 = player 1, 1 = player 2
//   joy1/joy2  - debounced player inputs, active-low
//   coin       - debounced coins, active-low
//   scan_done  - one-cycle pulse after each complete two-player scan
module jamma_joy_scanner
    import jamma_joy_scanner_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES    = 4,
    parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] jjoy,
    input  logic [5:0] local_joy,
    input  logic [1:0] jcoin,
    output logic       joy_select,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] coin,
    output logic       scan_done
);

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic        select_q, select_d;
    logic        scan_done_q, scan_done_d;

    logic [7:0]  p1_sample;
    logic        p1_en, p2_en;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        unique case (state_q)
            SETTLE1: begin
                if (settle_cnt_q == SettleLast) begin
                    state_d      = SAMPLE1;
                    settle_cnt_d = 8'd0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            SAMPLE1: state_d = SETTLE2;
            SETTLE2: begin
                if (settle_cnt_q == SettleLast) begin
                    state_d      = SAMPLE2;
                    settle_cnt_d = 8'd0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            SAMPLE2: state_d = SETTLE1;
            default: state_d = SETTLE1;
        endcase
        // Select follows the player of the next state, so it flips only on
        // entry to a settle window and is steady through the sample.
        select_d    = (state_d == SETTLE2) || (state_d == SAMPLE2);
        scan_done_d = (state_q == SAMPLE2);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q      <= SETTLE1;
            settle_cnt_q <= 8'd0;
            select_q     <= 1'b0;
            scan_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            select_q     <= select_d;
            scan_done_q  <= scan_done_d;
        end
    end

    assign joy_select = select_q;
    assign scan_done  = scan_done_q;

    assign p1_sample = jjoy & {2'b11, local_joy};
    assign p1_en     = (state_q == SAMPLE1);
    assign p2_en     = (state_q == SAMPLE2);

    joy_debounce #(
        .WIDTH   (8),
        .SAMPLES (DEBOUNCE_SAMPLES)
    ) u_p1_debounce (
        .pclk      (pclk),
        .reset     (reset),
        .sample_en (p1_en),
        .din       (p1_sample),
        .dout      (joy1)
    );

    joy_debounce #(
        .WIDTH   (8),
        .SAMPLES (DEBOUNCE_SAMPLES)
    ) u_p2_debounce (
        .pclk      (pclk),
        .reset     (reset),
        .sample_en (p2_en),
        .din       (jjoy),
        .dout      (joy2)
    );

    // Coins are not multiplexed; they ride along with the player 1 sample.
    joy_debounce #(
        .WIDTH   (2),
        .SAMPLES (DEBOUNCE_SAMPLES)
    ) u_coin_debounce (
        .pclk      (pclk),
        .reset     (reset),
        .sample_en (p1_en),
        .din       (jcoin),
        .dout      (coin)
    );

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// Self-checking bench for jamma_joy_scanner: directed scenarios followed by
// randomized stimulus, compared every cycle against a behavioural model that
// tracks scan position arithmetically and debounces with sample histories.
module tb_jamma_joy_scanner;

    localparam int unsigned S = 4;
    localparam int unsigned N = 3;
    localparam int unsigned P = 2 * (S + 1);

    logic       pclk = 1'b0;
    logic       reset;
    logic [7:0] jjoy;
    logic [5:0] local_joy;
    logic [1:0] jcoin;

    logic       joy_select, scan_done;
    logic [7:0] joy1, joy2;
    logic [1:0] coin;
    logic       sel_b, done_b;
    logic [7:0] joy1_b, joy2_b;
    logic [1:0] coin_b;

    jamma_joy_scanner #(
        .SETTLE_CYCLES    (S),
        .DEBOUNCE_SAMPLES (N)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .jjoy       (jjoy),
        .local_joy  (local_joy),
        .jcoin      (jcoin),
        .joy_select (joy_select),
        .joy1       (joy1),
        .joy2       (joy2),
        .coin       (coin),
        .scan_done  (scan_done)
    );

    // Single-sample build: outputs follow each sample directly.
    jamma_joy_scanner #(
        .SETTLE_CYCLES    (S),
        .DEBOUNCE_SAMPLES (1)
    ) dut_fast (
        .pclk       (pclk),
        .reset      (reset),
        .jjoy       (jjoy),
        .local_joy  (local_joy),
        .jcoin      (jcoin),
        .joy_select (sel_b),
        .joy1       (joy1_b),
        .joy2       (joy2_b),
        .coin       (coin_b),
        .scan_done  (done_b)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Player-level stimulus; the bus shows whichever player is selected.
    logic [7:0] p1v, p2v;

    // Model state: cycle position within the scan period and sample histories.
    int         pos;
    logic       exp_done;
    logic [7:0] p1_hist[$];
    logic [7:0] p2_hist[$];
    logic [1:0] c_hist[$];
    logic [7:0] e_joy1, e_joy2, f_joy1, f_joy2;
    logic [1:0] e_coin, f_coin;

    function automatic logic exp_sel(input int p);
        return (p >= int'(S + 1));
    endfunction

    task automatic model_reset();
        pos      = 0;
        exp_done = 1'b0;
        p1_hist.delete();
        p2_hist.delete();
        c_hist.delete();
        for (int i = 0; i < int'(N); i++) begin
            p1_hist.push_back(8'hFF);
            p2_hist.push_back(8'hFF);
            c_hist.push_back(2'b11);
        end
        e_joy1 = 8'hFF; e_joy2 = 8'hFF; e_coin = 2'b11;
        f_joy1 = 8'hFF; f_joy2 = 8'hFF; f_coin = 2'b11;
    endtask

    // Output moves to a value once the last N samples all equal it.
    task automatic model_edge();
        logic [7:0] v8;
        logic [1:0] v2;
        bit         same;
        if (reset) begin
            model_reset();
            return;
        end
        exp_done = (pos == int'(2 * S + 1));
        if (pos == int'(S)) begin
            v8 = jjoy & {2'b11, local_joy};
            p1_hist.push_back(v8);
            if (p1_hist.size() > int'(N)) void'(p1_hist.pop_front());
            same = 1'b1;
            foreach (p1_hist[i]) if (p1_hist[i] !== v8) same = 1'b0;
            if (same) e_joy1 = v8;
            f_joy1 = v8;
            v2 = jcoin;
            c_hist.push_back(v2);
            if (c_hist.size() > int'(N)) void'(c_hist.pop_front());
            same = 1'b1;
            foreach (c_hist[i]) if (c_hist[i] !== v2) same = 1'b0;
            if (same) e_coin = v2;
            f_coin = v2;
        end
        if (pos == int'(2 * S + 1)) begin
            v8 = jjoy;
            p2_hist.push_back(v8);
            if (p2_hist.size() > int'(N)) void'(p2_hist.pop_front());
            same = 1'b1;
            foreach (p2_hist[i]) if (p2_hist[i] !== v8) same = 1'b0;
            if (same) e_joy2 = v8;
            f_joy2 = v8;
        end
        pos = (pos + 1) % int'(P);
    endtask

    task automatic drive_bus();
        jjoy = exp_sel(pos) ? p2v : p1v;
    endtask

    // One clock: advance the model at the edge, compare 1 time unit later,
    // then re-drive the bus for the (possibly new) select value.
    task automatic tick();
        @(posedge pclk);
        model_edge();
        #1;
        check("joy_select", 8'(joy_select), 8'(exp_sel(pos)));
        check("scan_done", 8'(scan_done), 8'(exp_done));
        check("joy1", joy1, e_joy1);
        check("joy2", joy2, e_joy2);
        check("coin", 8'(coin), 8'(e_coin));
        check("fast_select", 8'(sel_b), 8'(exp_sel(pos)));
        check("fast_done", 8'(done_b), 8'(exp_done));
        check("fast_joy1", joy1_b, f_joy1);
        check("fast_joy2", joy2_b, f_joy2);
        check("fast_coin", 8'(coin_b), 8'(f_coin));
        drive_bus();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset     = 1'b1;
        p1v       = 8'hFF;
        p2v       = 8'hFF;
        local_joy = 6'h3F;
        jcoin     = 2'b11;
        model_reset();
        drive_bus();
        run(2);
        reset = 1'b0;

        // Idle scanning: select pattern, scan_done period, idle outputs.
        run(3 * P);
        check("idle_joy1", joy1, 8'hFF);
        check("idle_coin", 8'(coin), 8'h03);

        // Select-dependent bus values accepted after the third scan.
        p1v = 8'hFE; p2v = 8'h7F;
        drive_bus();
        run(2 * P);
        check("bus_joy1_early", joy1, 8'hFF);
        check("bus_joy2_early", joy2, 8'hFF);
        run(P);
        check("bus_joy1", joy1, 8'hFE);
        check("bus_joy2", joy2, 8'h7F);

        // Two-sample glitch on player 1 bit0.
        p1v = 8'hFF; p2v = 8'hFF;
        drive_bus();
        run(3 * P);
        p1v = 8'hFE;
        drive_bus();
        run(P);
        check("glitch_fast_joy1", joy1_b, 8'hFE);
        run(P);
        p1v = 8'hFF;
        drive_bus();
        run(3 * P);
        check("glitch_joy1", joy1, 8'hFF);

        // On-board joystick merges into player 1 only.
        local_joy = 6'b111011;
        run(3 * P);
        check("local_joy1", joy1, 8'hFB);
        check("local_joy2", joy2, 8'hFF);
        local_joy = 6'h3F;
        run(3 * P);

        // Coin press and release.
        jcoin = 2'b10;
        run(3 * P);
        check("coin_press", 8'(coin), 8'h02);
        jcoin = 2'b11;
        run(3 * P);
        check("coin_release", 8'(coin), 8'h03);

        // Reset in the middle of SETTLE2.
        p1v = 8'hFE;
        drive_bus();
        run(3 * P);
        check("pre_reset_joy1", joy1, 8'hFE);
        while (pos != int'(S + 2)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_joy1", joy1, 8'hFF);
        check("mid_reset_joy2", joy2, 8'hFF);
        check("mid_reset_coin", 8'(coin), 8'h03);
        check("mid_reset_select", 8'(joy_select), 8'h00);
        run(3 * P);
        check("reacquire_joy1", joy1, 8'hFE);

        // Randomized phase: sparse value changes, bit flaps, rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) p1v = 8'($urandom);
            if ($urandom_range(0, 15) == 0) p2v = 8'($urandom);
            if ($urandom_range(0, 31) == 0) p1v[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) local_joy = 6'($urandom);
            if ($urandom_range(0, 23) == 0) jcoin = 2'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            drive_bus();
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
